// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter and its display consumer.
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam int unsigned ADJ_THRESH  = 5;
    localparam int unsigned ADJ_ADD     = 3;

    localparam int unsigned IN_W_DEF    = 32;
    localparam int unsigned DIGITS_DEF  = 3;
    localparam int unsigned CNT_W_DEF   = 6;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_DIGIT_W'(ADJ_THRESH)) begin
            digit_o = digit_i + BCD_DIGIT_W'(ADJ_ADD);
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter; one input bit per cycle, result held
// until the next conversion completes.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned IN_W   = IN_W_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [IN_W-1:0]               in_data,
    output logic                          in_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          out_valid,
    output logic                          overflow,
    output logic                          busy
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;

    state_e             state_q, state_d;
    logic [IN_W-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               overflow_q, overflow_d;
    logic               out_valid_q, out_valid_d;

    logic [BCD_W-1:0]   work_adj;
    logic [BCD_W-1:0]   work_shl;
    logic               carry;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (work_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Bit leaving the top digit means the value has a nonzero digit above DIGITS.
    assign carry    = work_adj[BCD_W-1];
    assign work_shl = {work_adj[BCD_W-2:0], shift_q[IN_W-1]};

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        work_d      = work_q;
        ovf_acc_d   = ovf_acc_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d   = in_data;
                    work_d    = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                work_d    = work_shl;
                shift_d   = {shift_q[IN_W-2:0], 1'b0};
                ovf_acc_d = ovf_acc_q | carry;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(IN_W - 1)) begin
                    bcd_d       = work_shl;
                    overflow_d  = ovf_acc_q | carry;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            work_q      <= '0;
            ovf_acc_q   <= 1'b0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            work_q      <= work_d;
            ovf_acc_q   <= ovf_acc_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign bcd_out   = bcd_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule
